// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 select path.
// Issues a registered binary select and one-hot grant, bounds hold time, and inserts a one-cycle gap between owners.
module rr_decode_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] gnt_sel,
    output logic             gnt_valid,
    output logic [4:0]       hold_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] gnt_sel_q, gnt_sel_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [4:0]       hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             others_req;

    // Scan upward from the slot after the previous owner; the previous owner comes last.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] last);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last + SEL_W'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {pick_found, pick_idx} = rr_pick(req, last_ptr_q);
        others_req  = |(req & ~gnt_q);

        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_sel_d   = gnt_sel_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        last_ptr_d  = last_ptr_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (en && pick_found) begin
                    state_d     = ST_GRANT;
                    gnt_d       = ONE_HOT0 << pick_idx;
                    gnt_sel_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 5'd1;
                    last_ptr_d  = pick_idx;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_sel_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 5'd0;
                end
            end
            ST_GRANT: begin
                // A release takes precedence over a coincident timeout.
                if (!req[gnt_sel_q] || (hold_cnt_q == HOLD_MAX && others_req)) begin
                    state_d     = ST_GAP;
                    gnt_d       = '0;
                    gnt_sel_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 5'd0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    hold_cnt_d  = 5'd1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 5'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_sel_d   = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_sel_q   <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= 5'd0;
            last_ptr_q  <= SEL_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_sel_q   <= gnt_sel_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_sel   = gnt_sel_q;
    assign gnt_valid = gnt_valid_q;
    assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: a behavioural owner/hold model predicts each cycle's outputs,
// a monitor compares them and checks the grant invariants and grant order of directed scenarios.
module tb_rr_decode_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_sel;
    logic         gnt_valid;
    logic [4:0]   hold_cnt;

    rr_decode_arbiter #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_sel   (gnt_sel),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       vld;
        logic [4:0] hold;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: owner index (-1 = nobody), cycles held, previous owner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req_v, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = N - 1;
        end else if (m_owner >= 0) begin
            if (!q[m_owner]) begin
                m_owner = -1;
                m_held  = 0;
            end else if (m_held == 16) begin
                if ((q & ~(8'd1 << m_owner)) != 8'd0) begin
                    m_owner = -1;
                    m_held  = 0;
                end else begin
                    m_held = 1;
                end
            end else begin
                m_held++;
            end
        end else if (e && q != 8'd0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (q[c]) begin
                    m_owner = c;
                    m_held  = 1;
                    m_last  = c;
                    break;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] q);
        exp_t x;
        reset = r;
        en    = e;
        req   = q;
        model_step(r, e, q);
        x.vld  = (m_owner >= 0);
        x.gnt  = x.vld ? (8'd1 << m_owner) : 8'd0;
        x.sel  = x.vld ? 3'(m_owner) : 3'd0;
        x.hold = 5'(m_held);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Expected grant order packed as 4-bit entries, entry 0 in the low nibble.
    task automatic check_log(input string nm, input int n, input logic [63:0] order);
        logic [63:0] o;
        o = order;
        chk({nm, "_count"}, 32'(grant_log.size()), 32'(n));
        for (int i = 0; i < n && i < grant_log.size(); i++)
            chk({nm, "_order"}, 32'(grant_log[i]), 32'(o[4*i +: 4]));
    endtask

    logic [7:0] prev_gnt = 8'd0;
    logic       prev_vld = 1'b0;
    exp_t       mx;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mx = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(mx.gnt));
            chk("gnt_valid", 32'(gnt_valid), 32'(mx.vld));
            chk("hold_cnt", 32'(hold_cnt), 32'(mx.hold));
            if (mx.vld) chk("gnt_sel", 32'(gnt_sel), 32'(mx.sel));
            chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
            if (gnt_valid) chk("gnt_sel_match", 32'(gnt), 32'(8'd1 << gnt_sel));
            if (prev_gnt != 8'd0 && gnt != 8'd0) chk("no_adjacent_owners", 32'(gnt), 32'(prev_gnt));
            if (gnt_valid && !prev_vld) grant_log.push_back(int'(gnt_sel));
            prev_gnt = gnt;
            prev_vld = gnt_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        reset = 1'b1;
        en    = 1'b0;
        req   = 8'h00;

        // T1: reset with everyone requesting, then first grant goes to bit 0.
        grant_log.delete();
        cycle(1, 1, 8'hFF);
        cycle(1, 1, 8'hFF);
        cycle(0, 1, 8'hFF);
        cycle(0, 1, 8'hFF);
        settle();
        check_log("t1", 1, 64'h0);

        // T2: single requester, release, gap then idle.
        grant_log.delete();
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h10);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);
        settle();
        check_log("t2", 1, 64'h4);

        // T3: all request; each owner drops after holding 3 cycles, then re-raises.
        grant_log.delete();
        cycle(1, 1, 8'hFF);
        for (int i = 0; i < 35; i++) begin
            q = 8'hFF;
            if (m_owner >= 0 && m_held == 3) q = q & ~(8'd1 << m_owner);
            cycle(0, 1, q);
        end
        settle();
        check_log("t3", 9, 64'h076543210);

        // T4: timeout rotation between two steady requesters, then a lone requester.
        grant_log.delete();
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 40; i++) cycle(0, 1, 8'h05);
        settle();
        check_log("t4", 3, 64'h020);
        grant_log.delete();
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 40; i++) cycle(0, 1, 8'h01);
        settle();
        check_log("t4_alone", 1, 64'h0);

        // T5: previous owner 7 loses to bit 0 on the wrap.
        grant_log.delete();
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h80);
        for (int i = 0; i < 2; i++) cycle(0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h81);
        settle();
        check_log("t5", 2, 64'h07);

        // T6: en gating, then reset in the middle of a grant.
        grant_log.delete();
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h08);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'h08);
        cycle(1, 1, 8'h08);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h08);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h08);
        settle();
        check_log("t6", 2, 64'h33);

        // Random traffic against the reference model.
        q = 8'h00;
        cycle(1, 1, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic e;
            if ($urandom_range(0, 3) == 0) begin
                q = 8'($urandom);
                if ($urandom_range(0, 1) == 0) q = q & 8'($urandom);
            end
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) != 0);
            cycle(r, e, q);
        end
        settle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
